// File: rtl/aud_pkg.sv
// Shared types for the playback speed DSP: mode/state enums, speed limit, speed clamp.
// Combinational helpers only; no latency and no flow control.
package aud_pkg;

    localparam int MAX_SPEED = 8;

    typedef enum logic [1:0] {
        NORMAL      = 2'd0,
        FAST        = 2'd1,
        SLOW_HOLD   = 2'd2,
        SLOW_INTERP = 2'd3
    } aud_mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH0,
        S_FETCH1,
        S_CALC,
        S_HOLD,
        S_PAUSE
    } dsp_state_e;

    // A factor of 0 means 1x; anything above the limit saturates to it.
    function automatic logic [3:0] clamp_speed(input logic [3:0] spd, input logic [3:0] max_spd);
        if (spd == 4'd0)
            return 4'd1;
        else if (spd > max_spd)
            return max_spd;
        return spd;
    endfunction

endpackage

// File: rtl/aud_div_unit.sv
// Sequential restoring divider: signed W-bit dividend by unsigned 4-bit divisor, truncating toward zero.
// Latency W+1 clk from i_go to the o_valid pulse; i_go while busy restarts the division.
module aud_div_unit #(
    parameter int W = 21
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_go,
    input  logic [W-1:0] i_dividend,
    input  logic [3:0]   i_divisor,
    output logic         o_busy,
    output logic         o_valid,
    output logic [W-1:0] o_quotient
);

    logic [W-1:0] quot;
    logic [3:0]   rem;
    logic [3:0]   dvs;
    logic [4:0]   cnt;
    logic         neg;
    logic [4:0]   shifted;
    logic [5:0]   trial;

    // Remainder stays below the divisor, so four bits hold it between steps.
    assign shifted = {rem, quot[W-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dvs};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            quot       <= '0;
            rem        <= '0;
            dvs        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_quotient <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_go) begin
                quot   <= i_dividend[W-1] ? -i_dividend : i_dividend;
                rem    <= '0;
                dvs    <= i_divisor;
                neg    <= i_dividend[W-1];
                cnt    <= 5'(W);
                o_busy <= 1'b1;
            end else if (o_busy) begin
                if (cnt != 5'd0) begin
                    if (!trial[5]) begin
                        rem  <= trial[3:0];
                        quot <= {quot[W-2:0], 1'b1};
                    end else begin
                        rem  <= shifted[3:0];
                        quot <= {quot[W-2:0], 1'b0};
                    end
                    cnt <= cnt - 5'd1;
                end else begin
                    o_quotient <= neg ? -quot : quot;
                    o_valid    <= 1'b1;
                    o_busy     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/aud_speed_dsp.sv
// Playback speed DSP: SRAM fetch, skip/repeat/interp, one sample per LRCK frame (AUD_DSP_INTERP_EN enables interp).
// Sample is ready within the LRCK low phase after a falling edge; no backpressure, pause/stop freeze or rewind.
module aud_speed_dsp #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int MAX_SPEED = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic [1:0]        i_mode,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_daclrck,
    input  logic [DATA_W-1:0] i_sram_data,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_dac_data,
    output logic              o_en,
    output logic              o_done
);
    import aud_pkg::*;

    localparam int AW1 = ADDR_W + 1;
    localparam int QW  = DATA_W + 5;

    dsp_state_e        state, state_n;
    aud_mode_e         mode_q;
    logic              lrck_q, lrck_fall, play;
    logic              interp_in, interp_q, div_valid;
    logic [ADDR_W-1:0] pos;
    logic [AW1-1:0]    pos_ext;
    logic [3:0]        sub, sub_nx, n_q, n_in;
    logic [DATA_W-1:0] cur, sample, interp_sample;
    logic              past_end;

    assign lrck_fall = lrck_q & ~i_daclrck;
    assign n_in      = clamp_speed(i_speed, 4'(MAX_SPEED));
    assign play      = state inside {S_WAIT, S_FETCH0, S_FETCH1, S_CALC, S_HOLD};
    assign o_en      = play;
    assign past_end  = pos_ext > {1'b0, i_end_addr};

`ifdef AUD_DSP_INTERP_EN
    logic [DATA_W:0] diff;
    logic [QW-1:0]   prod, quot, sum;
    logic            div_busy;

    assign interp_in = (i_mode == SLOW_INTERP);
    assign interp_q  = (mode_q == SLOW_INTERP);
    // Next sample arrives during S_FETCH1; the divider is launched straight from it.
    assign diff = {i_sram_data[DATA_W-1], i_sram_data} - {cur[DATA_W-1], cur};
    assign prod = {{4{diff[DATA_W]}}, diff} * {{(QW-4){1'b0}}, sub};
    assign sum  = quot + {{5{cur[DATA_W-1]}}, cur};

    always_comb begin
        interp_sample = sum[DATA_W-1:0];
        if (sum[QW-1:DATA_W-1] != '0 && sum[QW-1:DATA_W-1] != '1)
            interp_sample = sum[QW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    aud_div_unit #(.W(QW)) u_div (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_go       (state == S_FETCH1),
        .i_dividend (prod),
        .i_divisor  (n_q),
        .o_busy     (div_busy),
        .o_valid    (div_valid),
        .o_quotient (quot)
    );
`else
    logic div_busy;
    assign interp_in     = 1'b0;
    assign interp_q      = 1'b0;
    assign div_valid     = 1'b0;
    assign div_busy      = 1'b0;
    assign interp_sample = '0;
`endif

    always_comb begin
        pos_ext = {1'b0, pos} + AW1'(1);
        sub_nx  = sub;
        case (mode_q)
            NORMAL: pos_ext = {1'b0, pos} + AW1'(1);
            FAST:   pos_ext = {1'b0, pos} + AW1'(n_q);
            default: begin
                if (sub + 4'd1 >= n_q) begin
                    sub_nx  = 4'd0;
                    pos_ext = {1'b0, pos} + AW1'(1);
                end else begin
                    sub_nx  = sub + 4'd1;
                    pos_ext = {1'b0, pos};
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (i_stop)
            state_n = S_IDLE;
        else if (i_pause && play)
            state_n = S_PAUSE;
        else begin
            case (state)
                S_IDLE:   if (i_start) state_n = S_WAIT;
                S_PAUSE:  if (i_start) state_n = S_WAIT;
                S_WAIT:   if (lrck_fall) state_n = S_FETCH0;
                S_FETCH0: state_n = interp_in ? S_FETCH1 : S_CALC;
                S_FETCH1: state_n = S_CALC;
                S_CALC:   if (!interp_q || (div_valid && !div_busy)) state_n = S_HOLD;
                S_HOLD:   state_n = past_end ? S_IDLE : S_WAIT;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lrck_q      <= 1'b0;
            pos         <= '0;
            sub         <= '0;
            n_q         <= 4'd1;
            mode_q      <= NORMAL;
            cur         <= '0;
            sample      <= '0;
            o_sram_addr <= '0;
            o_dac_data  <= '0;
            o_done      <= 1'b0;
        end else begin
            lrck_q <= i_daclrck;
            o_done <= 1'b0;
            if (i_stop) begin
                pos         <= '0;
                sub         <= '0;
                o_sram_addr <= '0;
                o_dac_data  <= '0;
            end else if (i_pause && play) begin
                o_dac_data <= '0;
            end else begin
                case (state)
                    S_IDLE: if (i_start) begin
                        pos <= '0;
                        sub <= '0;
                    end
                    S_WAIT: if (lrck_fall) o_sram_addr <= pos;
                    S_FETCH0: begin
                        cur    <= i_sram_data;
                        mode_q <= aud_mode_e'(i_mode);
                        n_q    <= n_in;
                        // At the last address the neighbour is the sample itself.
                        if (interp_in)
                            o_sram_addr <= (pos == i_end_addr) ? pos : pos + ADDR_W'(1);
                    end
                    S_CALC: begin
                        if (!interp_q)
                            sample <= cur;
                        else if (div_valid)
                            sample <= interp_sample;
                    end
                    S_HOLD: begin
                        o_dac_data <= sample;
                        if (past_end) begin
                            o_done <= 1'b1;
                            pos    <= '0;
                            sub    <= '0;
                        end else begin
                            pos <= pos_ext[ADDR_W-1:0];
                            sub <= sub_nx;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
